// File: rtl/aes128_share_ctrl.sv
// Round-robin arbiter sharing one combinational AES-128 core between NREQ requesters.
// Optional build macro AES_SHARE_ZEROIZE_EN clears operand/result registers on response handshake.
module aes128_share_ctrl #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned WAIT_CYCLES = 3,
    localparam int unsigned IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*128-1:0]   req_ptext,
    input  logic [NREQ*128-1:0]   req_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [127:0]          rsp_ctext,
    output logic [IDW-1:0]        rsp_id,
    output logic [127:0]          core_ptext,
    output logic [127:0]          core_key,
    input  logic [127:0]          core_ctext,
    output logic                  busy
);

    localparam int unsigned DW = 128;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  next_ptr;
    logic            grant_found;
    logic            accept;
    logic            capture;
    int              idx;

    // Scan from the highest offset down so the nearest valid requester after rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            if (req_valid[IDW'(idx)]) begin
                grant_found = 1'b1;
                grant       = IDW'(idx);
            end
        end
    end

    assign next_ptr = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_d          = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, settle counter and ciphertext capture (multicycle path ends at rsp_ctext).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            cur_id     <= '0;
            cnt        <= '0;
            core_ptext <= '0;
            core_key   <= '0;
            rsp_ctext  <= '0;
            rsp_id     <= '0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rsp_valid <= (state_d == ST_RESP);
            busy      <= (state_d != ST_IDLE);
            if (accept) begin
                core_ptext <= req_ptext[DW*grant +: DW];
                core_key   <= req_key[DW*grant +: DW];
                cur_id     <= grant;
                rr_ptr     <= next_ptr;
                cnt        <= CW'(WAIT_CYCLES - 1);
            end
            if (state_q == ST_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_ctext <= core_ctext;
                rsp_id    <= cur_id;
            end
`ifdef AES_SHARE_ZEROIZE_EN
            if (state_q == ST_RESP && rsp_ready) begin
                core_ptext <= '0;
                core_key   <= '0;
                rsp_ctext  <= '0;
            end
`else
`endif
        end
    end

endmodule

// File: tb/tb_aes128_share_ctrl.sv
// Self-checking bench for aes128_share_ctrl: directed vector table, reset abort,
// randomized round-robin traffic against a transaction model, and a WAIT_CYCLES=1 instance.
module tb_aes128_share_ctrl;

    localparam int unsigned NREQ = 4;
    localparam int unsigned WC   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*128-1:0]  req_ptext;
    logic [NREQ*128-1:0]  req_key;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [127:0]         rsp_ctext;
    logic [1:0]           rsp_id;
    logic [127:0]         core_ptext;
    logic [127:0]         core_key;
    logic [127:0]         core_ctext;
    logic                 busy;

    logic [NREQ-1:0]      w1_req_valid;
    logic [NREQ-1:0]      w1_req_ready;
    logic [NREQ*128-1:0]  w1_req_ptext;
    logic [NREQ*128-1:0]  w1_req_key;
    logic                 w1_rsp_valid;
    logic                 w1_rsp_ready;
    logic [127:0]         w1_rsp_ctext;
    logic [1:0]           w1_rsp_id;
    logic [127:0]         w1_core_ptext;
    logic [127:0]         w1_core_key;
    logic [127:0]         w1_core_ctext;
    logic                 w1_busy;

    logic [127:0] ptext_a [NREQ];
    logic [127:0] key_a   [NREQ];

    int n_chk  = 0;
    int n_pass = 0;
    int rr_m   = 0;

    always #5 clk = ~clk;

    // Stand-in for the AES core: known FIPS-197 vectors, otherwise a cheap keyed mix.
    function automatic logic [127:0] core_model(input logic [127:0] p, input logic [127:0] k);
        if (p == 128'h3243f6a8885a308d313198a2e0370734 && k == 128'h2b7e151628aed2a6abf7158809cf4f3c)
            return 128'h3925841d02dc09fbdc118597196a0b32;
        if (p == 128'h00112233445566778899aabbccddeeff && k == 128'h000102030405060708090a0b0c0d0e0f)
            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        return (p ^ {k[63:0], k[127:64]}) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    assign core_ctext    = core_model(core_ptext, core_key);
    assign w1_core_ctext = core_model(w1_core_ptext, w1_core_key);

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_ptext[128*i +: 128] = ptext_a[i];
            req_key[128*i +: 128]   = key_a[i];
        end
    end

    aes128_share_ctrl #(.NREQ(NREQ), .WAIT_CYCLES(WC)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ptext  (req_ptext),
        .req_key    (req_key),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_ctext  (rsp_ctext),
        .rsp_id     (rsp_id),
        .core_ptext (core_ptext),
        .core_key   (core_key),
        .core_ctext (core_ctext),
        .busy       (busy)
    );

    aes128_share_ctrl #(.NREQ(NREQ), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (w1_req_valid),
        .req_ready  (w1_req_ready),
        .req_ptext  (w1_req_ptext),
        .req_key    (w1_req_key),
        .rsp_valid  (w1_rsp_valid),
        .rsp_ready  (w1_rsp_ready),
        .rsp_ctext  (w1_rsp_ctext),
        .rsp_id     (w1_rsp_id),
        .core_ptext (w1_core_ptext),
        .core_key   (w1_core_key),
        .core_ctext (w1_core_ctext),
        .busy       (w1_busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on the WAIT_CYCLES=3 instance, starting and ending in IDLE.
    task automatic do_op(input logic [NREQ-1:0] mask, input int exp_id,
                         input logic [127:0] exp_ct, input int delay, input string tag);
        logic [NREQ-1:0] exp_rdy;
        logic [127:0]    exp_p, exp_k, exp_c;
        exp_rdy = NREQ'(1) << exp_id;
        req_valid = mask;
        #1;
        chk({tag, " req_ready"}, 128'(req_ready), 128'(exp_rdy));
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        chk({tag, " core_ptext"}, core_ptext, ptext_a[exp_id]);
        chk({tag, " core_key"}, core_key, key_a[exp_id]);
        chk({tag, " busy"}, 128'(busy), 128'(1));
        chk({tag, " ready_in_wait"}, 128'(req_ready), 128'(0));
        repeat (WC - 1) begin
            @(posedge clk); #1;
            chk({tag, " early_rsp_valid"}, 128'(rsp_valid), 128'(0));
        end
        @(posedge clk); #1;
        chk({tag, " rsp_valid"}, 128'(rsp_valid), 128'(1));
        chk({tag, " rsp_ctext"}, rsp_ctext, exp_ct);
        chk({tag, " rsp_id"}, 128'(rsp_id), 128'(exp_id));
        req_valid = mask;
        repeat (delay) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, 128'(rsp_valid), 128'(1));
            chk({tag, " hold_ctext"}, rsp_ctext, exp_ct);
            chk({tag, " hold_ready"}, 128'(req_ready), 128'(0));
        end
        rsp_ready = 1'b1;
        #1;
        chk({tag, " ready_at_hs"}, 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        chk({tag, " post_hs_valid"}, 128'(rsp_valid), 128'(0));
        chk({tag, " post_hs_busy"}, 128'(busy), 128'(0));
`ifdef AES_SHARE_ZEROIZE_EN
        exp_p = '0;
        exp_k = '0;
        exp_c = '0;
`else
        exp_p = ptext_a[exp_id];
        exp_k = key_a[exp_id];
        exp_c = exp_ct;
`endif
        chk({tag, " post_hs_ptext"}, core_ptext, exp_p);
        chk({tag, " post_hs_key"}, core_key, exp_k);
        chk({tag, " post_hs_ctext"}, rsp_ctext, exp_c);
        rr_m = (exp_id + 1) % int'(NREQ);
    endtask

    typedef struct {
        logic [NREQ-1:0] mask;
        int              id;
        logic [127:0]    pt;
        logic [127:0]    key;
        logic [127:0]    ct;
        int              delay;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rr_ids [5];
        int rdy_q [$];
        int rsp_q [$];
        logic [127:0] w1_p, w1_k;

        rst_n        = 1'b0;
        req_valid    = '0;
        rsp_ready    = 1'b0;
        w1_req_valid = '0;
        w1_rsp_ready = 1'b0;
        w1_p = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        w1_k = 128'hdeadbeefcafebabe0123456789abcdef;
        w1_req_ptext = {NREQ{w1_p}};
        w1_req_key   = {NREQ{w1_k}};
        for (int i = 0; i < int'(NREQ); i++) begin
            ptext_a[i] = 128'h00112233445566778899aabbccddee00 | 128'(i);
            key_a[i]   = 128'hf0e1d2c3b4a5968778695a4b3c2d1e00 | 128'(i);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst req_ready", 128'(req_ready), 128'(0));
        chk("rst core_ptext", core_ptext, 128'(0));
        chk("rst core_key", core_key, 128'(0));
        chk("rst rsp_ctext", rsp_ctext, 128'(0));
        chk("rst rsp_id", 128'(rsp_id), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rr_ids = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            vecs[k] = '{mask: 4'hF, id: rr_ids[k], pt: ptext_a[rr_ids[k]], key: key_a[rr_ids[k]],
                        ct: core_model(ptext_a[rr_ids[k]], key_a[rr_ids[k]]), delay: k % 2};
        end
        vecs[5] = '{mask: 4'b0001, id: 0, pt: 128'h3243f6a8885a308d313198a2e0370734,
                    key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32, delay: 0};
        vecs[6] = '{mask: 4'b0100, id: 2, pt: 128'h00112233445566778899aabbccddeeff,
                    key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, delay: 5};
        for (int v = 0; v < 7; v++) begin
            ptext_a[vecs[v].id] = vecs[v].pt;
            key_a[vecs[v].id]   = vecs[v].key;
            do_op(vecs[v].mask, vecs[v].id, vecs[v].ct, vecs[v].delay, $sformatf("vec%0d", v));
        end

        // Abort an operation from requester 2 mid-WAIT; arbitration must restart at 0.
        req_valid = 4'b0100;
        #1;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort rsp_valid", 128'(rsp_valid), 128'(0));
        chk("abort busy", 128'(busy), 128'(0));
        chk("abort req_ready", 128'(req_ready), 128'(0));
        chk("abort core_ptext", core_ptext, 128'(0));
        chk("abort core_key", core_key, 128'(0));
        chk("abort rsp_ctext", rsp_ctext, 128'(0));
        chk("abort rsp_id", 128'(rsp_id), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WC + 2) begin
            @(posedge clk); #1;
            chk("abort no_rsp", 128'(rsp_valid), 128'(0));
        end
        rr_m = 0;
        do_op(4'b1010, 1, core_model(ptext_a[1], key_a[1]), 0, "post_rst");

        // Random traffic: grant is the first pending requester at or after the model pointer.
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] mask;
            int gid;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < int'(NREQ); i++) begin
                ptext_a[i] = {$urandom, $urandom, $urandom, $urandom};
                key_a[i]   = {$urandom, $urandom, $urandom, $urandom};
            end
            gid = -1;
            for (int k = 0; k < int'(NREQ); k++) begin
                if (gid < 0 && mask[(rr_m + k) % int'(NREQ)]) gid = (rr_m + k) % int'(NREQ);
            end
            do_op(mask, gid, core_model(ptext_a[gid], key_a[gid]), int'($urandom_range(0, 3)),
                  $sformatf("rnd%0d", n));
        end

        // WAIT_CYCLES=1 instance: requester 1 back-to-back with consumer always ready.
        @(posedge clk); #1;
        w1_req_valid = 4'b0010;
        w1_rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (w1_req_ready[1]) rdy_q.push_back(c);
            if (w1_rsp_valid) begin
                rsp_q.push_back(c);
                chk("w1 rsp_ctext", w1_rsp_ctext, core_model(w1_p, w1_k));
                chk("w1 rsp_id", 128'(w1_rsp_id), 128'(1));
            end
        end
        w1_req_valid = '0;
        chk("w1 accept_count", 128'(rdy_q.size()), 128'(5));
        chk("w1 rsp_count", 128'(rsp_q.size()), 128'(5));
        for (int j = 0; j + 1 < rdy_q.size(); j++) begin
            chk("w1 accept_period", 128'(rdy_q[j+1] - rdy_q[j]), 128'(3));
        end
        for (int j = 0; j < rdy_q.size() && j < rsp_q.size(); j++) begin
            chk("w1 latency", 128'(rsp_q[j] - rdy_q[j] - 1), 128'(1));
        end
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes128_share_ctrl.md
# aes128_share_ctrl

Round-robin scheduler that shares a single combinational `my_aes128_coprocessor` instance between `NREQ` requesters. Each requester presents a plaintext/key pair with a valid/ready handshake. The controller latches the granted operands into registers that drive the core, and waits a fixed multicycle settle time. It then captures the ciphertext and returns it, tagged with the requester index, on a single valid/ready response channel.

## Interface
- `NREQ`, 4: number of requesters, 1..16.
- `WAIT_CYCLES`, 3: core settle cycles between operand load and ciphertext capture, ≥1. This is the multicycle path budget for the combinational core.
- `IDW`, `NREQ>1 ? $clog2(NREQ) : 1`: requester index width (derived; not overridden).

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  bit i: requester i has an operation pending.
- `req_ready`  out  NREQ  bit i: requester i is accepted this cycle (one-hot or zero).
- `req_ptext`  in  NREQ*128  requester i plaintext at bits [128*i +: 128].
- `req_key`  in  NREQ*128  requester i key at bits [128*i +: 128].
- `rsp_valid`  out  1  ciphertext available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_ctext`  out  128  captured ciphertext.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_ctext`.
- `core_ptext`  out  128  registered plaintext to the core.
- `core_key`  out  128  registered key to the core.
- `core_ctext`  in  128  combinational ciphertext from the core.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - Grant is the first i with `req_valid[i]=1`, searching from `rr_ptr` upward modulo NREQ.
  - `req_ready[grant]=1` combinationally; all other bits are 0.
  - `req_ready` is all zero if no `req_valid` bit is set.
  - On the accepting edge:
    - `core_ptext`/`core_key` load the granted operands.
    - `cur_id` is set to the granted index.
    - `rr_ptr` is set to (grant+1) mod NREQ.
    - `cnt` is set to WAIT_CYCLES-1.
    - The FSM moves to WAIT.
- **WAIT:**
  - `req_ready` is all zero.
  - Each edge with `cnt≠0` decrements `cnt`.
  - The edge with `cnt==0` captures `core_ctext` into `rsp_ctext` and `cur_id` into `rsp_id`, then moves to RESP.
- **RESP:**
  - `rsp_valid=1`; `rsp_ctext` and `rsp_id` are held stable while `rsp_valid && !rsp_ready`.
  - The edge with `rsp_ready=1` moves to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- `req_valid` deassertion without a handshake is ignored; requesters must hold `valid` and operands stable until `ready`.
- Reset values:
  - State IDLE, `rr_ptr=0`, `cnt=0`.
  - `core_ptext=0`, `core_key=0`, `rsp_ctext=0`, `rsp_id=0`.
  - `rsp_valid=0`, `req_ready=0`, `busy=0`.
- Reset mid-operation aborts the operation; no response is produced for it.
- NREQ=1: `rr_ptr` stays 0 and `rsp_id` is 0.

## Timing
- Request accepted at edge T.
  - `core_*` is valid from T.
  - Ciphertext is captured at edge T+WAIT_CYCLES.
  - `rsp_valid` is high from T+WAIT_CYCLES.
- Response handshake at edge R: IDLE from R, next accept at R+1 at the earliest.
- Peak throughput is one operation per WAIT_CYCLES+2 cycles.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.
- `core_ctext` is sampled only at the capture edge. A multicycle constraint of WAIT_CYCLES applies from `core_ptext`/`core_key` to the `rsp_ctext` registers.

## Configuration
- **`AES_SHARE_ZEROIZE_EN` defined:**
  - On the response-handshake edge, `core_ptext`, `core_key` and `rsp_ctext` are cleared to 0.
  - `rsp_ctext` therefore reads 0 whenever `rsp_valid=0` after the first response.
- **Undefined:**
  - These registers retain their last values until overwritten.
- Handshake timing is identical in both builds.

## Test plan
- Requester 0, ptext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, WAIT_CYCLES=3, `rsp_ready=1` -> `rsp_valid` 3 cycles after accept, `rsp_ctext` 3925841d02dc09fbdc118597196a0b32, `rsp_id=0`.
- Requesters 0..3 all valid continuously, each with its index as its only varying operand byte -> grants in order 0,1,2,3,0. Each `rsp_id` matches the operands; no requester starves.
- Requester 2, ptext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, `rsp_ready` low for 5 cycles -> `rsp_ctext` 69c4e0d86a7b0430d8cdb78070b4c55a, held stable; no `req_ready` asserted until 1 cycle after handshake.
- `rst_n` pulsed low during WAIT -> all outputs at reset values immediately; no `rsp_valid` for the aborted operation; the next request is serviced normally with `rr_ptr` starting at 0.
- With `AES_SHARE_ZEROIZE_EN`, after the first test's handshake -> `core_ptext`, `core_key` and `rsp_ctext` all 0. Without it -> values retained.
- WAIT_CYCLES=1, back-to-back requests from requester 1 -> accept-to-`rsp_valid` latency 1 and a 3-cycle period between accepts.
